// File: rtl/alu_pkg.sv
// Shared opcodes and FSM state encoding for the multi-cycle execute ALU.
// Imported by alu_mc and alu_mul_iter.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, MUL_BITS multiplier bits per cycle, LSB first.
// done/product are combinational in the final iteration so the caller can latch.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int MUL_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int N  = WIDTH / MUL_BITS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;

    // Partial product of the shifted multiplicand and the low MUL_BITS multiplier bits.
    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (b_q[i]) begin
                partial = partial + (a_q << i);
            end
        end
        acc_next = acc_q + partial;
    end

    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == CW'(N - 1));
    assign product = acc_next;

    // Operand shift registers, accumulator and iteration counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            a_q    <= a;
            b_q    <= b;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            a_q   <= a_q << MUL_BITS;
            b_q   <= b_q >> MUL_BITS;
            acc_q <= acc_next;
            cnt_q <= cnt_q + CW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute ALU with valid/ready on both sides and registered result.
// Define ALU_MUL_EN to build the iterative multiplier; otherwise MUL is an unknown op.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int MUL_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       alu_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    if (WIDTH < 8) begin : g_chk_width
        $error("alu_mc: WIDTH must be >= 8");
    end
    if (WIDTH % MUL_BITS != 0) begin : g_chk_mul
        $error("alu_mc: WIDTH must be a multiple of MUL_BITS");
    end

    alu_state_t       state_q;
    alu_state_t       state_d;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;
    logic             zero_q;
    logic [WIDTH-1:0] alu_res;

    logic is_and;
    logic is_or;
    logic is_add;
    logic is_sub;
    logic is_slt;
    logic is_nor;

    assign is_and = (alu_sel == ALU_AND);
    assign is_or  = (alu_sel == ALU_OR);
    assign is_add = (alu_sel == ALU_ADD);
    assign is_sub = (alu_sel == ALU_SUB);
    assign is_slt = (alu_sel == ALU_SLT);
    assign is_nor = (alu_sel == ALU_NOR);

`ifdef ALU_MUL_EN
    logic             is_mul;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    assign is_mul = (alu_sel == ALU_MUL);

    alu_mul_iter #(
        .WIDTH    (WIDTH),
        .MUL_BITS (MUL_BITS)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (op1),
        .b       (op2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
`endif

    // Single-cycle datapath; unknown opcodes (and MUL here) give zero.
    always_comb begin
        alu_res = '0;
        unique case (1'b1)
            is_and:  alu_res = op1 & op2;
            is_or:   alu_res = op1 | op2;
            is_add:  alu_res = op1 + op2;
            is_sub:  alu_res = op1 - op2;
            is_slt:  alu_res = WIDTH'($signed(op1) < $signed(op2));
            is_nor:  alu_res = ~(op1 | op2);
            default: alu_res = '0;
        endcase
    end

    // Next-state, handshake outputs and next result value.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef ALU_MUL_EN
        mul_start = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef ALU_MUL_EN
                    if (is_mul) begin
                        mul_start = 1'b1;
                        state_d   = S_BUSY;
                    end else begin
                        result_d = alu_res;
                        state_d  = S_DONE;
                    end
`else
                    result_d = alu_res;
                    state_d  = S_DONE;
`endif
                end
            end
            S_BUSY: begin
`ifdef ALU_MUL_EN
                if (mul_done) begin
                    result_d = mul_product;
                    state_d  = S_DONE;
                end else if (!mul_busy) begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; zero tracks the registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= ~|result_d;
        end
    end

    assign result = result_q;
    assign zero   = zero_q;

endmodule
